// File: rtl/sum_share_arb_pkg.sv
// Shared definitions for the round-robin arbiter in front of the single FP adder.
// State encoding is visible on the bus analyser, so keep the values fixed.
package sum_share_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/sum_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from (last_i + 1) mod N, wrapping.
module sum_share_arb_rr_pick
    import sum_share_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] winner_o,
    output logic          any_req_o
);

    int idx;

    always_comb begin
        winner_o  = '0;
        any_req_o = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_i) + k) % N;
            if (!any_req_o && req_i[idx]) begin
                winner_o  = IW'(idx);
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sum_share_arb.sv
// Round-robin sequencer sharing one external FP adder between N requesters,
// with a watchdog that turns a hung adder transaction into an error completion.
module sum_share_arb
    import sum_share_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*32-1:0] a_in,
    input  logic [N*32-1:0] b_in,
    output logic [N-1:0]    done,
    output logic [N-1:0]    gnt,
    output logic [31:0]     res_out,
    output logic            err_out,
    output logic            busy,
    output logic            add_ri,
    output logic [31:0]     add_a,
    output logic [31:0]     add_b,
    input  logic            add_ro,
    input  logic [31:0]     add_res
);

    localparam int            IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q;
    logic [N-1:0]  gnt_q;
    logic [N-1:0]  done_q;
    logic [31:0]   res_q;
    logic          err_q;
    logic          busy_q;
    logic          add_ri_q;
    logic [31:0]   add_a_q;
    logic [31:0]   add_b_q;
    logic [TW-1:0] timer_q;
    logic [IW-1:0] last_q;
    logic [IW-1:0] win_q;

    logic [IW-1:0] winner;
    logic          any_req;
    logic [N-1:0]  gnt_d;
    logic [31:0]   a_sel_d;
    logic [31:0]   b_sel_d;

    sum_share_arb_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i     (req),
        .last_i    (last_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    assign gnt_d   = {{(N-1){1'b0}}, 1'b1} << winner;
    assign a_sel_d = a_in[int'(winner)*32 +: 32];
    assign b_sel_d = b_in[int'(winner)*32 +: 32];

    // All outputs are registered; pulses (add_ri, done) are set on the
    // transition into their state and self-clear one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            res_q    <= FP_ZERO;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            add_ri_q <= 1'b0;
            add_a_q  <= FP_ZERO;
            add_b_q  <= FP_ZERO;
            timer_q  <= '0;
            last_q   <= IW'(N - 1);
            win_q    <= '0;
        end else begin
            done_q   <= '0;
            add_ri_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_q    <= gnt_d;
                        add_a_q  <= a_sel_d;
                        add_b_q  <= b_sel_d;
                        win_q    <= winner;
                        add_ri_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the timeout cycle still wins over the abort.
                    if (add_ro) begin
                        res_q   <= add_res;
                        err_q   <= 1'b0;
                        done_q  <= gnt_q;
                        state_q <= S_DONE;
                    end else if (timer_q == TMO_LAST) begin
                        res_q   <= FP_ZERO;
                        err_q   <= 1'b1;
                        done_q  <= gnt_q;
                        state_q <= S_DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DONE: begin
                    last_q  <= win_q;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done    = done_q;
    assign gnt     = gnt_q;
    assign res_out = res_q;
    assign err_out = err_q;
    assign busy    = busy_q;
    assign add_ri  = add_ri_q;
    assign add_a   = add_a_q;
    assign add_b   = add_b_q;

endmodule

// File: tb/tb_sum_share_arb.sv
// Directed bench for sum_share_arb with a behavioural adder whose completion
// arrives lat_cfg+1 cycles after the add_ri cycle (lat_cfg < 0: never).
module tb_sum_share_arb;
    import sum_share_arb_pkg::*;

    localparam logic [31:0] FP_TWO  = 32'h4000_0000;
    localparam logic [31:0] FP_2P5  = 32'h4020_0000;
    localparam logic [31:0] FP_1P5  = 32'h3FC0_0000;
    localparam logic [31:0] FP_FOUR = 32'h4080_0000;
    localparam logic [31:0] G0      = 32'd1;
    localparam logic [31:0] G1      = 32'd2;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [1:0]  done;
    logic [1:0]  gnt;
    logic [31:0] res_out;
    logic        err_out;
    logic        busy;
    logic        add_ri;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_ro;
    logic [31:0] add_res;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int oh_bad = 0;

    int          lat_cfg = 1;
    int          mdl_cnt = 0;
    logic        mdl_ro  = 1'b0;
    logic        inj_ro  = 1'b0;
    logic [31:0] inj_res = 32'h0;

    sum_share_arb #(.N(2), .TIMEOUT(64), .TW(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .done    (done),
        .gnt     (gnt),
        .res_out (res_out),
        .err_out (err_out),
        .busy    (busy),
        .add_ri  (add_ri),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_ro  (add_ro),
        .add_res (add_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fp_add_model(input logic [31:0] a, input logic [31:0] b);
        if (a == FP_ONE && b == FP_ONE) return FP_TWO;
        if (a == FP_2P5 && b == FP_1P5) return FP_FOUR;
        return 32'hFFFF_FFFF;
    endfunction

    always @(negedge clk) begin
        if (add_ri) begin
            mdl_cnt = (lat_cfg < 0) ? 0 : lat_cfg + 1;
            mdl_ro  = 1'b0;
        end else if (mdl_cnt > 0) begin
            mdl_cnt = mdl_cnt - 1;
            mdl_ro  = (mdl_cnt == 0);
        end else begin
            mdl_ro = 1'b0;
        end
    end

    assign add_ro  = mdl_ro | inj_ro;
    assign add_res = inj_ro ? inj_res : fp_add_model(add_a, add_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if ($countones(gnt) > 1) oh_bad++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 2'b00;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_ri(input int budget);
        int n = 0;
        while (!add_ri && n < budget) begin
            step();
            n++;
        end
        check("add_ri_seen", 32'(add_ri), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done == 2'b00 && n < budget) begin
            step();
            n++;
        end
        check("done_seen", 32'(done != 2'b00), 32'd1);
    endtask

    initial begin
        int ri_c, dc_c, ri_n, bad, dn;
        logic [31:0] a_iss;
        logic [1:0]  done_v;
        logic [31:0] res_v;
        logic        err_v;

        reset = 1'b0;
        req   = 2'b00;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt",   32'(gnt),     32'd0);
        check("rst_done",  32'(done),    32'd0);
        check("rst_busy",  32'(busy),    32'd0);
        check("rst_ri",    32'(add_ri),  32'd0);
        check("rst_err",   32'(err_out), 32'd0);
        check("rst_res",   res_out,      32'd0);
        check("rst_add_a", add_a,        32'd0);
        check("rst_add_b", add_b,        32'd0);

        // Single transaction, adder latency 3.
        reset = 1'b1;
        lat_cfg = 3;
        a_in[31:0] = FP_ONE;
        b_in[31:0] = FP_ONE;
        req = 2'b01;
        cyc = 0;
        ri_c = -1; dc_c = -1; ri_n = 0; a_iss = '0;
        done_v = '0; res_v = '0; err_v = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (add_ri) begin
                ri_n++;
                ri_c = cyc;
                a_iss = add_a;
            end
            if (done != 2'b00) begin
                dc_c = cyc;
                done_v = done;
                res_v = res_out;
                err_v = err_out;
                req = 2'b00;
            end
        end
        check("t1_ri_count", 32'(ri_n), 32'd1);
        check("t1_ri_cycle", 32'(ri_c), 32'd1);
        check("t1_add_a",    a_iss,     FP_ONE);
        check("t1_done_cyc", 32'(dc_c), 32'd6);
        check("t1_done_val", 32'(done_v), G0);
        check("t1_res",      res_v,     FP_TWO);
        check("t1_err",      32'(err_v), 32'd0);

        // Both requesters held: strict alternation starting at 0.
        do_reset();
        lat_cfg = 1;
        a_in = {FP_ONE, FP_2P5};
        b_in = {FP_ONE, FP_1P5};
        req = 2'b11;
        oh_bad = 0;
        for (int t = 0; t < 4; t++) begin
            wait_done(20);
            check("rr_gnt",  32'(gnt),     (t % 2 == 0) ? G0 : G1);
            check("rr_done", 32'(done),    (t % 2 == 0) ? G0 : G1);
            check("rr_res",  res_out,      (t % 2 == 0) ? FP_FOUR : FP_TWO);
            check("rr_err",  32'(err_out), 32'd0);
            if (t == 3) req = 2'b00;
            step();
            check("rr_idle_busy", 32'(busy), 32'd0);
        end
        check("rr_onehot", 32'(oh_bad), 32'd0);

        // Adder never answers: watchdog abort, then a normal transaction.
        lat_cfg = -1;
        a_in = {FP_ONE, FP_ONE};
        b_in = {FP_ONE, FP_ONE};
        req = 2'b01;
        wait_ri(10);
        ri_c = cyc;
        wait_done(100);
        dc_c = cyc;
        req = 2'b00;
        check("to_latency", 32'(dc_c - ri_c), 32'd65);
        check("to_done",    32'(done),        G0);
        check("to_err",     32'(err_out),     32'd1);
        check("to_res",     res_out,          32'd0);
        lat_cfg = 1;
        step();
        req = 2'b10;
        wait_done(20);
        req = 2'b00;
        check("post_to_done", 32'(done),    G1);
        check("post_to_res",  res_out,      FP_TWO);
        check("post_to_err",  32'(err_out), 32'd0);
        step();

        // Reset asserted while waiting on the adder; late add_ro must be ignored.
        lat_cfg = 10;
        req = 2'b01;
        wait_ri(10);
        repeat (3) step();
        reset = 1'b0;
        req = 2'b00;
        #1;
        check("wrst_gnt",   32'(gnt),    32'd0);
        check("wrst_busy",  32'(busy),   32'd0);
        check("wrst_add_a", add_a,       32'd0);
        check("wrst_res",   res_out,     32'd0);
        check("wrst_ri",    32'(add_ri), 32'd0);
        step();
        step();
        reset = 1'b1;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (done != 2'b00) dn++;
        end
        check("late_ro_done", 32'(dn),   32'd0);
        check("late_ro_res",  res_out,   32'd0);
        check("late_ro_busy", 32'(busy), 32'd0);
        lat_cfg = 1;
        a_in = {FP_2P5, FP_ONE};
        b_in = {FP_1P5, FP_ONE};
        req = 2'b11;
        wait_ri(10);
        check("post_rst_gnt", 32'(gnt), G0);
        wait_done(20);
        req = 2'b00;
        check("post_rst_done", 32'(done), G0);
        check("post_rst_res",  res_out,   FP_TWO);
        step();

        // add_ro while idle must not disturb anything.
        inj_res = 32'h1234_5678;
        inj_ro = 1'b1;
        step();
        inj_ro = 1'b0;
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done != 2'b00) dn++;
        end
        check("idle_ro_done", 32'(dn),   32'd0);
        check("idle_ro_res",  res_out,   FP_TWO);
        check("idle_ro_busy", 32'(busy), 32'd0);

        // add_ro coincides with the last watchdog cycle: completion wins.
        lat_cfg = 63;
        a_in[31:0] = FP_2P5;
        b_in[31:0] = FP_1P5;
        req = 2'b01;
        wait_ri(10);
        ri_c = cyc;
        wait_done(100);
        dc_c = cyc;
        req = 2'b00;
        check("edge_latency", 32'(dc_c - ri_c), 32'd65);
        check("edge_err",     32'(err_out),     32'd0);
        check("edge_res",     res_out,          FP_FOUR);
        step();

        // Operands are captured only in IDLE.
        lat_cfg = 3;
        a_in[31:0] = FP_ONE;
        b_in[31:0] = FP_ONE;
        req = 2'b01;
        wait_ri(10);
        a_in[31:0] = FP_2P5;
        b_in[31:0] = FP_1P5;
        bad = 0;
        for (int c = 0; c < 20 && done == 2'b00; c++) begin
            step();
            if (add_a != FP_ONE || add_b != FP_ONE) bad++;
        end
        req = 2'b00;
        check("hold_done",    32'(done), G0);
        check("hold_changes", 32'(bad),  32'd0);
        check("hold_add_a",   add_a,     FP_ONE);
        check("hold_res",     res_out,   FP_TWO);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
